// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) game core.
package genius_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    APPEND,
    WIN,
    LOSE
  } state_e;

  typedef enum logic {
    MODE_SIGA     = 1'b0,
    MODE_MANDO_EU = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    DIFF_HARD  = 2'b00,
    DIFF_MED   = 2'b01,
    DIFF_EASY  = 2'b10,
    DIFF_PRACT = 2'b11
  } diff_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/genius_lfsr.sv
// Free-running Galois LFSR; exposes only the low OUT_W bits used as a colour code.
module genius_lfsr #(
  parameter int               WIDTH = 16,
  parameter int               OUT_W = 2,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [OUT_W-1:0] q
);

  logic [WIDTH-1:0] lfsr_r;

  // Shift right, folding the taps in whenever a one falls out of bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= SEED;
    end else if (en) begin
      lfsr_r <= (lfsr_r >> 1) ^ (lfsr_r[0] ? TAPS : '0);
    end
  end

  assign q = lfsr_r[OUT_W-1:0];

endmodule

// File: rtl/genius_core_n.sv
// Genius (Simon) game core for N colours: sequence memory, display timing,
// press decoding with multi-press and idle-timeout detection.
module genius_core_n
  import genius_pkg::*;
#(
  parameter int NUM_COLORS     = 4,
  parameter int COLOR_CODEFY_W = $clog2(NUM_COLORS),
  parameter int ADDR_WIDTH     = 5,
  parameter int MAX_LEN        = 31,
  parameter int LFSR_WIDTH     = 16,
  parameter int TGT_HARD       = 31,
  parameter int TGT_MED        = 16,
  parameter int TGT_EASY       = 8,
  parameter int TGT_PRACT      = 4,
  parameter int SHOW_FAST      = 8,
  parameter int SHOW_SLOW      = 16,
  parameter int TIMEOUT        = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode_button,
  input  logic [1:0]            difficulty_button,
  input  logic                  speed_button,
  input  logic [NUM_COLORS-1:0] button,
  output logic [NUM_COLORS-1:0] led,
  output logic [ADDR_WIDTH-1:0] lcd_display,
  output logic                  win,
  output logic                  lose,
  output logic                  busy
);

  localparam int CW           = COLOR_CODEFY_W;
  localparam int CNT_MAX_SHOW = (SHOW_SLOW > SHOW_FAST) ? SHOW_SLOW : SHOW_FAST;
  localparam int CNT_MAX      = (TIMEOUT > CNT_MAX_SHOW) ? TIMEOUT : CNT_MAX_SHOW;
  localparam int CNT_W        = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN_A = ADDR_WIDTH'(MAX_LEN);
  localparam logic [CNT_W-1:0]      ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0]      TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [NUM_COLORS-1:0] ONE_N     = NUM_COLORS'(1);

  function automatic logic [NUM_COLORS-1:0] code_to_onehot(input logic [CW-1:0] code);
    return ONE_N << code;
  endfunction

  function automatic logic [CW-1:0] onehot_to_code(input logic [NUM_COLORS-1:0] oh);
    logic [CW-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_COLORS; i++) code = oh[i] ? CW'(i) : code;
    return code;
  endfunction

  state_e                  state_r, state_n;
  mode_e                   mode_r, mode_n;
  diff_e                   diff_r, diff_n;
  logic                    speed_r, speed_n;
  logic [ADDR_WIDTH-1:0]   len_r, len_n, idx_r, idx_n, score_r, score_n, target_s;
  logic [CNT_W-1:0]        cnt_r, cnt_n, show_t_s, half_s;
  logic [NUM_COLORS-1:0]   btn_q_r, edge_s, led_r, led_n;
  logic                    start_q_r, start_edge_s, valid_s, multi_s;
  logic                    win_r, lose_r, busy_r, busy_n;
  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   mem_waddr_s;
  logic [CW-1:0]           mem_wdata_s, lfsr_color_s, press_code_s, show_code_s;
  logic [CW-1:0]           mem_r [0:MAX_LEN-1];

  genius_lfsr #(
    .WIDTH (LFSR_WIDTH),
    .OUT_W (CW),
    .TAPS  (LFSR_WIDTH'(LFSR_TAPS)),
    .SEED  (LFSR_WIDTH'(LFSR_SEED))
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .q     (lfsr_color_s)
  );

  assign start_edge_s = start & ~start_q_r;
  assign edge_s       = button & ~btn_q_r;
  assign valid_s      = (edge_s != '0) && ((edge_s & (edge_s - ONE_N)) == '0);
  assign multi_s      = (edge_s != '0) && !valid_s;
  assign press_code_s = onehot_to_code(edge_s);
  assign show_t_s     = speed_r ? CNT_W'(SHOW_FAST) : CNT_W'(SHOW_SLOW);
  assign half_s       = ((show_t_s >> 1) == '0) ? ONE_C : (show_t_s >> 1);

  // Target length selected by the captured difficulty.
  always_comb begin
    case (diff_r)
      DIFF_HARD: target_s = ADDR_WIDTH'(TGT_HARD);
      DIFF_MED:  target_s = ADDR_WIDTH'(TGT_MED);
      DIFF_EASY: target_s = ADDR_WIDTH'(TGT_EASY);
      default:   target_s = ADDR_WIDTH'(TGT_PRACT);
    endcase
  end

  // Next-state, sequence bookkeeping and memory write control.
  always_comb begin
    state_n     = state_r;
    mode_n      = mode_r;
    diff_n      = diff_r;
    speed_n     = speed_r;
    len_n       = len_r;
    idx_n       = idx_r;
    score_n     = score_r;
    cnt_n       = cnt_r;
    mem_we_s    = 1'b0;
    mem_waddr_s = len_r;
    mem_wdata_s = lfsr_color_s;
    if (start_edge_s) begin
      mode_n  = mode_e'(mode_button);
      diff_n  = diff_e'(difficulty_button);
      speed_n = speed_button;
      len_n   = '0;
      idx_n   = '0;
      score_n = '0;
      cnt_n   = '0;
      state_n = mode_button ? APPEND : ADD;
    end else begin
      case (state_r)
        ADD: begin
          if (len_r < MAX_LEN_A) begin
            mem_we_s = 1'b1;
            len_n    = len_r + ONE_A;
          end else begin
            len_n = len_r;
          end
          idx_n   = '0;
          cnt_n   = '0;
          state_n = SHOW_ON;
        end
        SHOW_ON: begin
          if (cnt_r == show_t_s - ONE_C) begin
            cnt_n   = '0;
            state_n = SHOW_OFF;
          end else begin
            cnt_n = cnt_r + ONE_C;
          end
        end
        SHOW_OFF: begin
          if (cnt_r != half_s - ONE_C) begin
            cnt_n = cnt_r + ONE_C;
          end else if (idx_r < len_r - ONE_A) begin
            cnt_n   = '0;
            idx_n   = idx_r + ONE_A;
            state_n = SHOW_ON;
          end else begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = WAIT_IN;
          end
        end
        WAIT_IN: begin
          if (multi_s) begin
            state_n = LOSE;
          end else if (valid_s) begin
            cnt_n = '0;
            if (press_code_s != mem_r[idx_r]) begin
              state_n = LOSE;
            end else if (idx_r < len_r - ONE_A) begin
              idx_n = idx_r + ONE_A;
            end else if (mode_r == MODE_MANDO_EU) begin
              state_n = APPEND;
            end else begin
              score_n = (len_r >= target_s) ? target_s : len_r;
              state_n = (len_r >= target_s) ? WIN : ADD;
            end
          end else if (cnt_r == TIMEOUT_C - ONE_C) begin
            state_n = LOSE;
          end else begin
            cnt_n = cnt_r + ONE_C;
          end
        end
        APPEND: begin
          if (multi_s) begin
            state_n = LOSE;
          end else if (valid_s) begin
            cnt_n = '0;
            idx_n = '0;
            if (len_r < MAX_LEN_A) begin
              mem_we_s    = 1'b1;
              mem_wdata_s = press_code_s;
              len_n       = len_r + ONE_A;
            end else begin
              len_n = len_r;
            end
            score_n = (len_n >= target_s) ? target_s : len_n;
            state_n = (len_n >= target_s) ? WIN : WAIT_IN;
          end else if (cnt_r == TIMEOUT_C - ONE_C) begin
            state_n = LOSE;
          end else begin
            cnt_n = cnt_r + ONE_C;
          end
        end
        default: state_n = state_r;
      endcase
    end
  end

  // The colour shown next cycle may be the one being written this cycle (ADD into slot 0).
  assign show_code_s = (mem_we_s && (mem_waddr_s == idx_n)) ? mem_wdata_s : mem_r[idx_n];

  // Output values for the upcoming state, registered below so they line up with it.
  always_comb begin
    case (state_n)
      SHOW_ON:         led_n = code_to_onehot(show_code_s);
      WAIT_IN, APPEND: led_n = button;
      default:         led_n = '0;
    endcase
    case (state_n)
      IDLE, WIN, LOSE: busy_n = 1'b0;
      default:         busy_n = 1'b1;
    endcase
  end

  // Sequence memory; contents are meaningless until written in the current game.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mode_r    <= MODE_SIGA;
      diff_r    <= DIFF_HARD;
      speed_r   <= 1'b0;
      len_r     <= '0;
      idx_r     <= '0;
      score_r   <= '0;
      cnt_r     <= '0;
      btn_q_r   <= '0;
      start_q_r <= 1'b0;
      led_r     <= '0;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      mode_r    <= mode_n;
      diff_r    <= diff_n;
      speed_r   <= speed_n;
      len_r     <= len_n;
      idx_r     <= idx_n;
      score_r   <= score_n;
      cnt_r     <= cnt_n;
      btn_q_r   <= button;
      start_q_r <= start;
      led_r     <= led_n;
      win_r     <= (state_n == WIN);
      lose_r    <= (state_n == LOSE);
      busy_r    <= busy_n;
    end
  end

  assign led         = led_r;
  assign lcd_display = score_r;
  assign win         = win_r;
  assign lose        = lose_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_genius_core_n.sv
// Directed bench for genius_core_n: both game modes, display timing, timeout,
// multi-press, restart and asynchronous reset.
module tb_genius_core_n;

  localparam logic [3:0] G = 4'b0001;
  localparam logic [3:0] R = 4'b0010;
  localparam logic [3:0] B = 4'b0100;

  logic       clk, rst_n, start, mode_button, speed_button;
  logic [1:0] difficulty_button;
  logic [3:0] button, led;
  logic [4:0] lcd_display;
  logic       win, lose, busy;

  int         total, bad;
  logic [3:0] seq [0:7];

  genius_core_n dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .mode_button       (mode_button),
    .difficulty_button (difficulty_button),
    .speed_button      (speed_button),
    .button            (button),
    .led               (led),
    .lcd_display       (lcd_display),
    .win               (win),
    .lose              (lose),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic [3:0] m);
    button = m;
    tick();
    button = 4'b0;
    tick();
  endtask

  task automatic hit(input logic [3:0] m);
    button = m;
    tick();
    button = 4'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // Fast display: each element 8 cycles lit then 4 dark; earlier elements must repeat.
  task automatic run_show(input int n);
    logic [3:0] col;
    int         on_cnt, off_cnt;
    for (int e = 0; e < n; e++) begin
      col = led;
      on_cnt = 0;
      off_cnt = 0;
      check("show_onehot", 32'($onehot(col)), 32'd1);
      if (e < n - 1) check("show_prefix", 32'(col), 32'(seq[e]));
      seq[e] = col;
      for (int c = 0; c < 8; c++) begin
        if (led === col) on_cnt++;
        tick();
      end
      for (int c = 0; c < 4; c++) begin
        if (led === 4'b0) off_cnt++;
        tick();
      end
      check("show_on_cycles", 32'(on_cnt), 32'd8);
      check("show_off_cycles", 32'(off_cnt), 32'd4);
    end
  endtask

  initial begin
    int zero_cnt;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode_button = 1'b0;
    difficulty_button = 2'b00;
    speed_button = 1'b0;
    button = 4'b0;
    #12;
    check("rst_led", 32'(led), 32'd0);
    check("rst_lcd", 32'(lcd_display), 32'd0);
    check("rst_win", 32'(win), 32'd0);
    check("rst_lose", 32'(lose), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tap(G);
    check("idle_press_busy", 32'(busy), 32'd0);
    check("idle_press_led", 32'(led), 32'd0);

    // MANDO_EU, target 4: G; G+G; G,G+R; G,G,R+B.
    mode_button = 1'b1;
    difficulty_button = 2'b11;
    start = 1'b1;
    tick();
    check("m_start_busy", 32'(busy), 32'd1);
    check("m_start_lcd", 32'(lcd_display), 32'd0);
    start = 1'b0;
    tick();
    hit(G);
    check("m_len1", 32'(lcd_display), 32'd1);
    check("m_led_mirror", 32'(led), 32'(G));
    tick();
    tap(G);
    hit(G);
    check("m_len2", 32'(lcd_display), 32'd2);
    tick();
    tap(G); tap(G);
    hit(R);
    check("m_len3", 32'(lcd_display), 32'd3);
    tick();
    tap(G); tap(G); tap(R);
    hit(B);
    check("m_len4", 32'(lcd_display), 32'd4);
    check("m_win", 32'(win), 32'd1);
    check("m_win_busy", 32'(busy), 32'd0);
    check("m_win_lose", 32'(lose), 32'd0);
    tick();
    check("m_win_led", 32'(led), 32'd0);

    // MANDO_EU mismatch: sequence G,G then G,R.
    pulse_start();
    check("ml_win_cleared", 32'(win), 32'd0);
    tap(G); tap(G); tap(G); tap(G);
    hit(R);
    check("ml_lose", 32'(lose), 32'd1);
    check("ml_win", 32'(win), 32'd0);
    check("ml_lcd", 32'(lcd_display), 32'd2);
    check("ml_busy", 32'(busy), 32'd0);
    tick();

    // Timeout: lose exactly 64 cycles after entering WAIT_IN.
    pulse_start();
    hit(G);
    check("to_lcd", 32'(lcd_display), 32'd1);
    for (int i = 0; i < 63; i++) tick();
    check("to_before", 32'(lose), 32'd0);
    tick();
    check("to_at", 32'(lose), 32'd1);

    // Two colours rising together.
    pulse_start();
    tap(G);
    hit(G | R);
    check("multi_lose", 32'(lose), 32'd1);
    check("multi_lcd", 32'(lcd_display), 32'd1);
    tick();

    // SIGA, fast display, target 4.
    mode_button = 1'b0;
    speed_button = 1'b1;
    start = 1'b1;
    tick();
    check("s_start_lose", 32'(lose), 32'd0);
    check("s_start_busy", 32'(busy), 32'd1);
    start = 1'b0;
    tick();
    for (int r = 1; r <= 4; r++) begin
      run_show(r);
      for (int e = 0; e < r - 1; e++) tap(seq[e]);
      hit(seq[r-1]);
      check("s_round_lcd", 32'(lcd_display), 32'(r));
      check("s_round_win", 32'(win), (r == 4) ? 32'd1 : 32'd0);
      check("s_round_busy", 32'(busy), (r == 4) ? 32'd0 : 32'd1);
      tick();
    end

    // Restart during SHOW_OFF of round 3.
    pulse_start();
    run_show(1);
    hit(seq[0]);
    check("rs_r1", 32'(lcd_display), 32'd1);
    tick();
    run_show(2);
    tap(seq[0]);
    hit(seq[1]);
    check("rs_r2", 32'(lcd_display), 32'd2);
    tick();
    for (int i = 0; i < 8; i++) tick();
    check("rs_showoff_led", 32'(led), 32'd0);
    start = 1'b1;
    tick();
    check("rs_lcd", 32'(lcd_display), 32'd0);
    check("rs_busy", 32'(busy), 32'd1);
    start = 1'b0;
    tick();
    run_show(1);
    zero_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (led === 4'b0) zero_cnt++;
      tick();
    end
    check("rs_len1_dark", 32'(zero_cnt), 32'd12);
    hit(seq[0]);
    check("rs_len1_lcd", 32'(lcd_display), 32'd1);
    tick();
    run_show(2);

    // Start coinciding with a (double) press in WAIT_IN.
    start = 1'b1;
    button = G | R;
    tick();
    check("sp_lose", 32'(lose), 32'd0);
    check("sp_lcd", 32'(lcd_display), 32'd0);
    check("sp_busy", 32'(busy), 32'd1);
    start = 1'b0;
    button = 4'b0;
    tick();
    check("sp_show", 32'($onehot(led)), 32'd1);

    // Asynchronous reset in SHOW_ON.
    rst_n = 1'b0;
    #1;
    check("ar_led", 32'(led), 32'd0);
    check("ar_lcd", 32'(lcd_display), 32'd0);
    check("ar_win", 32'(win), 32'd0);
    check("ar_lose", 32'(lose), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    check("ar_idle_busy", 32'(busy), 32'd0);
    check("ar_idle_led", 32'(led), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/genius_core_n.md
# genius_core_n

Parametrised game core for the Genius (Simon) design. It generalises the fixed 4-colour controller to N colours, a configurable sequence depth and per-difficulty target lengths, and adds input timeout and multi-press detection. It sits under `top`, between the debounced button/switch inputs and the LED/LCD drivers.

## Interface
Parameters:
- `NUM_COLORS`, default 4: number of colour channels. Power of two, 2..8.
- `COLOR_CODEFY_W`, default $clog2(NUM_COLORS): colour code width.
- `ADDR_WIDTH`, default 5: sequence index and score width.
- `MAX_LEN`, default 31: sequence memory depth. Must be ≤ 2**ADDR_WIDTH−1.
- `LFSR_WIDTH`, default 16: random generator width.
- `TGT_HARD`, default 31: target length for difficulty 00. Every `TGT_*` must be ≤ MAX_LEN.
- `TGT_MED`, default 16: target length for difficulty 01.
- `TGT_EASY`, default 8: target length for difficulty 10.
- `TGT_PRACT`, default 4: target length for difficulty 11.
- `SHOW_FAST`, default 8: LED-on cycles per element when speed=1.
- `SHOW_SLOW`, default 16: LED-on cycles per element when speed=0.
- `TIMEOUT`, default 64: idle cycles allowed while waiting for input.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `start` in 1: rising edge starts or restarts a game.
- `mode_button` in 1: 0 = SIGA (machine extends the sequence), 1 = MANDO_EU (player extends it).
- `difficulty_button` in 2: selects the target length.
- `speed_button` in 1: 1 = fast display.
- `button` in NUM_COLORS: debounced, synchronous colour buttons, level.
- `led` out NUM_COLORS: one-hot or zero.
- `lcd_display` out ADDR_WIDTH: score.
- `win` out 1.
- `lose` out 1.
- `busy` out 1: high in any state other than IDLE, WIN or LOSE.

## Operation
- Reset: every output 0, state IDLE, len 0, LFSR loaded with 16'hACE1 (nonzero).
- The LFSR free-runs every cycle: Galois, taps 0xB400. New colour = lfsr[COLOR_CODEFY_W-1:0].
- Press detect: `btn_q` registers `button`; `edge = button & ~btn_q`.
  - Valid press: `edge` one-hot.
  - Two or more bits set in `edge` in the same cycle: wrong press.
- `start` edge, in any state: capture mode, difficulty and speed; clear len, idx, score, win and lose.
  - SIGA goes to ADD.
  - MANDO_EU goes to APPEND.
- States:
  - IDLE.
  - ADD: mem[len] ← LFSR colour, len++, then SHOW_ON with idx=0.
  - SHOW_ON: `led` = onehot(mem[idx]) for T cycles.
  - SHOW_OFF: `led` = 0 for T/2 cycles. If idx+1 < len, idx++ and return to SHOW_ON. Otherwise idx=0 and go to WAIT_IN.
  - WAIT_IN: on a valid press, compare with mem[idx].
    - Mismatch or wrong press: go to LOSE.
    - Match with idx < len−1: idx++.
    - Match on the last element (SIGA): score = len. If score == target go to WIN, else go to ADD.
    - Match on the last element (MANDO_EU): go to APPEND.
  - APPEND (MANDO_EU only): on a valid press, mem[len] ← pressed colour, len++, score = len. If score == target go to WIN, else go to WAIT_IN with idx=0. Wrong press goes to LOSE.
  - WIN / LOSE: hold until the next `start` edge.
- T = SHOW_FAST or SHOW_SLOW. T/2 has a minimum of 1.
- Presses in IDLE, ADD, SHOW_*, WIN or LOSE are ignored. `btn_q` still tracks the buttons.
- `led` in WAIT_IN / APPEND mirrors `btn_q`. `led` is 0 in IDLE, WIN and LOSE.
- Timeout counter:
  - Counts in WAIT_IN and APPEND.
  - Clears on every accepted press and on entry to those states.
  - Reaching TIMEOUT goes to LOSE.
- `score` saturates at target and never wraps. len never exceeds MAX_LEN.

## Timing
- Press latency is one cycle. `button` rises before edge k, and the state, score, win and lose updates are visible after edge k.
- ADD takes 1 cycle. SHOW_ON starts on the following cycle.
- A `start` edge wins over a simultaneous colour press.
- Asynchronous reset mid-operation clears everything immediately. Memory contents are don't-care after reset.
- `win` and `lose` are registered and mutually exclusive.

## Structure
- `genius_pkg` holds:
  - the `state_e` enum: IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, APPEND, WIN, LOSE;
  - the `mode_e` and `diff_e` codes;
  - the LFSR seed and tap constants.
- Sub-module `genius_lfsr`, parametrised by LFSR_WIDTH, TAPS and SEED, with enable tied high.
- Sequence memory is a flop array inside the core.

## Test plan
- Reset during SHOW_ON with rst_n=0 → led=0, lcd_display=0, win=lose=busy=0 in the same cycle. State IDLE after release.
- MANDO_EU, difficulty 11 (target 4), presses G; G+G; G,G+R; G,G,R+B → lcd_display steps 1,2,3,4. win=1 and busy=0 one cycle after B.
- MANDO_EU with sequence G,G: repeat G, then press R → lose=1 one cycle after R. lcd_display stays 2.
- SIGA, speed=1: led one-hot for exactly 8 cycles, then 0 for 4 cycles. The bench replays the shown colours each round. lcd_display increments per round, and win rises at 4 with difficulty 11.
- WAIT_IN with no press → lose asserts exactly 64 cycles after WAIT_IN entry. Separately, G+R pressed in the same cycle → lose.
- `start` edge during SHOW_OFF of round 3 → lcd_display=0, len restarts at 1. A `start` edge coinciding with a press → restart, press ignored.
